// File: rtl/spi_txn_scheduler.sv
// rtl/spi_txn_scheduler.sv - round-robin transaction scheduler sharing one SPIMaster between clients
//
// Purpose:
//   Arbitrates NUMREQ client requests onto a single SPIMaster. The winner's data word and
//   slave ID are latched, Request is raised, and the Done handshake (resynchronised into mainclk)
//   is followed to completion. A one-cycle ack is then returned to the granted client.
//   Out-of-range slave IDs are rejected without touching the SPIMaster (ack with ack_err).
//
// Optional feature:
//   SPI_SCHED_TIMEOUT_EN - when defined, a Done-wait watchdog of TIMEOUT_CYC cycles runs across
//   WAIT_LO/WAIT_HI and completes the transfer with ack_err when it expires.
//
// Ports:
//   mainclk       in   system clock, all logic on posedge
//   reset         in   synchronous, active-high
//   req_i         in   [NUMREQ]         per-client request level, held until ack
//   req_data_i    in   [NUMREQ*DWIDTH]  packed client words, client i at [i*DWIDTH +: DWIDTH]
//   req_slave_i   in   [NUMREQ*32]      packed target slave IDs, client i at [i*32 +: 32]
//   ack_o         out  [NUMREQ]         one-cycle completion pulse to the granted client
//   ack_err_o     out  qualifies ack_o: rejected ID or timeout
//   busy_o        out  high whenever the FSM is not IDLE
//   grant_idx_o   out  index of the current or last granted client
//   m_data_o      out  [DWIDTH] to SPIMaster Data, stable from ISSUE through COMPLETE
//   m_id_o        out  [32] to SPIMaster ID
//   m_request_o   out  to SPIMaster Request
//   m_done_i      in   from SPIMaster Done, asynchronous

module spi_txn_scheduler #(
   parameter int NUMREQ      = 4,
   parameter int DWIDTH      = 8,
   parameter int NUMSLAVES   = 1,
   parameter int GAP_CYCLES  = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                        mainclk,
   input  logic                        reset,
   input  logic [NUMREQ-1:0]           req_i,
   input  logic [NUMREQ*DWIDTH-1:0]    req_data_i,
   input  logic [NUMREQ*32-1:0]        req_slave_i,
   output logic [NUMREQ-1:0]           ack_o,
   output logic                        ack_err_o,
   output logic                        busy_o,
   output logic [$clog2(NUMREQ)-1:0]   grant_idx_o,
   output logic [DWIDTH-1:0]           m_data_o,
   output logic [31:0]                 m_id_o,
   output logic                        m_request_o,
   input  logic                        m_done_i
);

   localparam int IW = $clog2(NUMREQ);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   generate
      if (NUMREQ < 2 || NUMREQ > 8 || GAP_CYCLES < 1 || TIMEOUT_CYC < 1 || NUMSLAVES < 1)
      begin : g_bad_param
         $error("spi_txn_scheduler: parameter out of range");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ISSUE    = 3'd1,
      S_WAIT_LO  = 3'd2,
      S_WAIT_HI  = 3'd3,
      S_COMPLETE = 3'd4
   } state_t;

   state_t              state_q;
   logic [IW-1:0]       rr_ptr_q;
   logic [GW-1:0]       gap_q;
   logic [NUMREQ-1:0]   ack_q;
   logic                ack_err_q;
   logic [IW-1:0]       grant_idx_q;
   logic [DWIDTH-1:0]   m_data_q;
   logic [31:0]         m_id_q;
   logic                m_request_q;
   logic                done_s1_q;
   logic                done_s2_q;

`ifdef SPI_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0]       tmo_q;
`endif

   // Round-robin pick: first requesting client at or after rr_ptr, wrapping.
   logic [IW-1:0]       win_idx;
   logic                win_vld;
   logic [IW-1:0]       rr_next;
   logic [DWIDTH-1:0]   win_data;
   logic [31:0]         win_slave;

   always_comb begin
      int cand;
      cand    = 0;
      win_idx = '0;
      win_vld = 1'b0;
      for (int i = 0; i < NUMREQ; i++) begin
         cand = (int'(rr_ptr_q) + i) % NUMREQ;
         if (!win_vld && req_i[cand[IW-1:0]]) begin
            win_vld = 1'b1;
            win_idx = cand[IW-1:0];
         end
      end
   end

   assign rr_next   = IW'((int'(win_idx) + 1) % NUMREQ);
   assign win_data  = req_data_i[int'(win_idx)*DWIDTH +: DWIDTH];
   assign win_slave = req_slave_i[int'(win_idx)*32 +: 32];

   always_ff @(posedge mainclk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         gap_q       <= GW'(GAP_CYCLES);
         ack_q       <= '0;
         ack_err_q   <= 1'b0;
         grant_idx_q <= '0;
         m_data_q    <= '0;
         m_id_q      <= '0;
         m_request_q <= 1'b0;
         done_s1_q   <= 1'b0;
         done_s2_q   <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         // Two-flop resynchroniser for the asynchronous Done.
         done_s1_q <= m_done_i;
         done_s2_q <= done_s1_q;

         // ack/ack_err are single-cycle pulses; only the transitions into COMPLETE set them.
         ack_q     <= '0;
         ack_err_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - GW'(1);
               end else if (win_vld) begin
                  grant_idx_q <= win_idx;
                  rr_ptr_q    <= rr_next;
                  m_data_q    <= win_data;
                  m_id_q      <= win_slave;
                  if (win_slave >= 32'(NUMSLAVES)) begin
                     // Unknown slave: reject without ever raising Request.
                     state_q   <= S_COMPLETE;
                     ack_q     <= NUMREQ'(1) << win_idx;
                     ack_err_q <= 1'b1;
                  end else begin
                     state_q <= S_ISSUE;
                  end
               end
            end

            S_ISSUE: begin
               m_request_q <= 1'b1;
               state_q     <= S_WAIT_LO;
`ifdef SPI_SCHED_TIMEOUT_EN
               tmo_q       <= '0;
`endif
            end

            S_WAIT_LO: begin
               // A Done still high from the previous transfer is stale; wait for the
               // master to clear it before looking for the completing edge.
               if (!done_s2_q) begin
                  state_q <= S_WAIT_HI;
               end
`ifdef SPI_SCHED_TIMEOUT_EN
               if (tmo_q == TMO_LAST) begin
                  state_q     <= S_COMPLETE;
                  ack_q       <= NUMREQ'(1) << grant_idx_q;
                  ack_err_q   <= 1'b1;
                  m_request_q <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
`endif
            end

            S_WAIT_HI: begin
`ifdef SPI_SCHED_TIMEOUT_EN
               if (tmo_q == TMO_LAST) begin
                  state_q     <= S_COMPLETE;
                  ack_q       <= NUMREQ'(1) << grant_idx_q;
                  ack_err_q   <= 1'b1;
                  m_request_q <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
`endif
               // Having seen Done low in WAIT_LO, any high here is a genuine rising edge.
               // It takes precedence over a coincident timeout.
               if (done_s2_q) begin
                  state_q     <= S_COMPLETE;
                  ack_q       <= NUMREQ'(1) << grant_idx_q;
                  ack_err_q   <= 1'b0;
                  m_request_q <= 1'b0;
               end
            end

            S_COMPLETE: begin
               m_request_q <= 1'b0;
               gap_q       <= GW'(GAP_CYCLES);
               state_q     <= S_IDLE;
            end

            default: begin
               state_q     <= S_IDLE;
               m_request_q <= 1'b0;
               gap_q       <= GW'(GAP_CYCLES);
            end
         endcase
      end
   end

   assign ack_o       = ack_q;
   assign ack_err_o   = ack_err_q;
   assign busy_o      = (state_q != S_IDLE);
   assign grant_idx_o = grant_idx_q;
   assign m_data_o    = m_data_q;
   assign m_id_o      = m_id_q;
   assign m_request_o = m_request_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// tb/tb_spi_txn_scheduler.sv - directed self-checking bench for spi_txn_scheduler

module tb_spi_txn_scheduler;

   localparam int NUMREQ      = 4;
   localparam int DWIDTH      = 8;
   localparam int NUMSLAVES   = 1;
   localparam int GAP_CYCLES  = 4;
   localparam int TIMEOUT_CYC = 64;

   logic                      mainclk;
   logic                      reset;
   logic [NUMREQ-1:0]         req;
   logic [NUMREQ*DWIDTH-1:0]  req_data;
   logic [NUMREQ*32-1:0]      req_slave;
   logic [NUMREQ-1:0]         ack;
   logic                      ack_err;
   logic                      busy;
   logic [1:0]                grant_idx;
   logic [DWIDTH-1:0]         m_data;
   logic [31:0]               m_id;
   logic                      m_request;
   logic                      m_done;

   int n_checks = 0;
   int n_errors = 0;

   spi_txn_scheduler #(
      .NUMREQ      (NUMREQ),
      .DWIDTH      (DWIDTH),
      .NUMSLAVES   (NUMSLAVES),
      .GAP_CYCLES  (GAP_CYCLES),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .mainclk     (mainclk),
      .reset       (reset),
      .req_i       (req),
      .req_data_i  (req_data),
      .req_slave_i (req_slave),
      .ack_o       (ack),
      .ack_err_o   (ack_err),
      .busy_o      (busy),
      .grant_idx_o (grant_idx),
      .m_data_o    (m_data),
      .m_id_o      (m_id),
      .m_request_o (m_request),
      .m_done_i    (m_done)
   );

   initial mainclk = 1'b0;
   always #5 mainclk = ~mainclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full transfer for client cli: grant, Request latency, Done handshake, ack timing.
   task automatic serve(input int cli, input logic [7:0] dat, input bit chk_gap, input string tag);
      int n;
      n = 0;
      while (!busy && n < 100) begin
         @(negedge mainclk);
         n++;
      end
      check({tag, "_granted"}, 32'(busy), 32'd1);
      if (chk_gap) check({tag, "_gap"}, 32'(n >= GAP_CYCLES), 32'd1);
      check({tag, "_grant_idx"}, 32'(grant_idx), 32'(cli));
      check({tag, "_req_at_grant"}, 32'(m_request), 32'd0);
      check({tag, "_m_data"}, 32'(m_data), 32'(dat));
      check({tag, "_m_id"}, m_id, 32'd0);
      req_data[cli*8 +: 8] = ~dat;
      @(negedge mainclk);
      check({tag, "_req_lat"}, 32'(m_request), 32'd1);
      @(negedge mainclk);
      m_done = 1'b0;
      repeat (DWIDTH) @(negedge mainclk);
      m_done = 1'b1;
      n = 0;
      while (ack == '0 && n < 20) begin
         @(negedge mainclk);
         n++;
      end
      check({tag, "_ack_lat"}, 32'(n), 32'd3);
      check({tag, "_ack"}, 32'(ack), 32'(1 << cli));
      check({tag, "_ack_err"}, 32'(ack_err), 32'd0);
      check({tag, "_req_drop"}, 32'(m_request), 32'd0);
      check({tag, "_m_data_hold"}, 32'(m_data), 32'(dat));
      req_data[cli*8 +: 8] = dat;
      @(negedge mainclk);
      check({tag, "_ack_width"}, 32'(ack), 32'd0);
   endtask

   initial begin
      int  n;
      bit  saw;

      reset     = 1'b1;
      req       = '0;
      req_data  = '0;
      req_slave = '0;
      m_done    = 1'b0;
      repeat (3) @(negedge mainclk);
      reset = 1'b0;

      // Reset values
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_ack_err", 32'(ack_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant_idx), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_m_id", m_id, 32'd0);
      check("rst_m_req", 32'(m_request), 32'd0);

      // Test 1: single client 0, word A5
      req_data[7:0] = 8'hA5;
      req = 4'b0001;
      serve(0, 8'hA5, 1'b1, "t1");
      req = 4'b0000;

      // Test 3: client 2 targets slave 5, rejected; Request never raised
      req_slave[2*32 +: 32] = 32'd5;
      req = 4'b0100;
      saw = 1'b0;
      n = 0;
      while (ack == '0 && n < 40) begin
         @(negedge mainclk);
         saw = saw | m_request;
         n++;
      end
      check("t3_ack", 32'(ack), 32'b0100);
      check("t3_ack_err", 32'(ack_err), 32'd1);
      check("t3_no_request", 32'(saw), 32'd0);
      check("t3_m_id", m_id, 32'd5);
      req = 4'b0000;
      @(negedge mainclk);
      check("t3_ack_width", 32'(ack), 32'd0);
      check("t3_err_width", 32'(ack_err), 32'd0);
      req_slave[2*32 +: 32] = 32'd0;

      // Test 4: reset in WAIT_HI aborts with no ack
      req_data[7:0] = 8'h3C;
      req = 4'b0001;
      m_done = 1'b1;
      n = 0;
      while (!busy && n < 100) begin
         @(negedge mainclk);
         n++;
      end
      @(negedge mainclk);
      m_done = 1'b0;
      repeat (4) @(negedge mainclk);
      check("t4_pre_req", 32'(m_request), 32'd1);
      check("t4_pre_data", 32'(m_data), 32'h3C);
      reset = 1'b1;
      @(negedge mainclk);
      check("t4_ack", 32'(ack), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_grant", 32'(grant_idx), 32'd0);
      check("t4_m_data", 32'(m_data), 32'd0);
      check("t4_m_req", 32'(m_request), 32'd0);
      reset = 1'b0;
      req = 4'b0000;
      m_done = 1'b1;
      saw = 1'b0;
      repeat (10) begin
         @(negedge mainclk);
         saw = saw | (ack != '0);
      end
      check("t4_no_ack", 32'(saw), 32'd0);

      // Test 2: all clients held; rr_ptr restarted at 0 by reset
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      req = 4'b1111;
      serve(0, 8'h11, 1'b0, "t2a");
      serve(1, 8'h22, 1'b1, "t2b");
      serve(2, 8'h33, 1'b1, "t2c");
      serve(3, 8'h44, 1'b1, "t2d");
      serve(0, 8'h11, 1'b1, "t2e");

      // Test 5: client 1 withdraws before grant, client 3 held
      req = 4'b1010;
      @(negedge mainclk);
      req = 4'b1000;
      serve(3, 8'h44, 1'b0, "t5");
      req = 4'b0000;
      saw = 1'b0;
      repeat (20) begin
         @(negedge mainclk);
         saw = saw | busy;
      end
      check("t5_no_extra", 32'(saw), 32'd0);

`ifdef SPI_SCHED_TIMEOUT_EN
      // Test 6: Done never rises; watchdog completes with ack_err
      m_done = 1'b0;
      req = 4'b0001;
      n = 0;
      while (!m_request && n < 100) begin
         @(negedge mainclk);
         n++;
      end
      check("t6_req", 32'(m_request), 32'd1);
      n = 0;
      while (ack == '0 && n < 200) begin
         @(negedge mainclk);
         n++;
      end
      check("t6_tmo_lat", 32'(n), 32'(TIMEOUT_CYC));
      check("t6_ack", 32'(ack), 32'b0001);
      check("t6_ack_err", 32'(ack_err), 32'd1);
      check("t6_req_drop", 32'(m_request), 32'd0);
      req = 4'b0000;
      @(negedge mainclk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
